countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Loadable down-counter / interval timer; the counting complement of the 4-bit up counter.
//  Software or an FSM loads a start value; the block decrements on enabled edges to zero.
//  Signals expiry with a one-cycle done pulse. Optionally auto-reloads for periodic ticks.
//  Sits beside the up counter in datapath control as the event/timeout generator.
// PARAMETERS
//  WIDTH   4   bit width of count_out, load_value and internal reload register
// PORTS
//  clock        in   1      single clock; all state updates on posedge
//  reset        in   1      asynchronous, active-high; clears all state immediately
//  clear        in   1      synchronous abort: count to 0, IDLE, no done pulse
//  load         in   1      capture load_value into counter and reload register
//  load_value   in   WIDTH  start / reload value
//  enable       in   1      active-high count enable; decrement only on enabled edges
//  auto_reload  in   1      1 = periodic (reload at terminal), 0 = one-shot
//  count_out    out  WIDTH  current count (registered)
//  busy         out  1      registered; high while state == RUN
//  done_pulse   out  1      registered; high exactly one cycle per expiry
//  zero         out  1      combinational: count_out == 0
// BEHAVIOUR
//  Reset (async, any time incl. mid-run): count_out=0, reload_reg=0, state=IDLE,
//   busy=0, done_pulse=0, zero=1. Takes effect without waiting for a clock edge.
//  States: IDLE, RUN. busy is high iff RUN.
//  Edge priority: reset > clear > load > decrement. done_pulse defaults to 0 on every edge.
//  clear: count_out<=0, state<=IDLE, reload_reg unchanged, done_pulse<=0.
//  load: count_out<=load_value, reload_reg<=load_value; state<=RUN if load_value!=0,
//   else IDLE. Allowed in any state; a load on the terminal edge suppresses done_pulse.
//  RUN, enable=1, count_out>1: count_out<=count_out-1.
//  RUN, enable=1, count_out==1 (terminal): done_pulse<=1;
//   auto_reload=1: count_out<=reload_reg, stay RUN (period = reload_reg enabled cycles);
//   auto_reload=0: count_out<=0, state<=IDLE.
//  RUN, enable=0: hold count_out and state; pending terminal waits for enable.
//  IDLE: enable ignored; count never decrements below 0 (no wrap to all-ones).
//  Latency: done_pulse and the new count_out appear in the same cycle after the terminal edge.
//  auto_reload is sampled only on the terminal edge; changing it mid-run is legal.
//  load_value=2^WIDTH-1 is legal: expiry after 2^WIDTH-1 enabled edges.
// TESTING
//  T1 one-shot: load=1,load_value=3 then enable=1 -> count_out 3,2,1,0; done_pulse high
//     only in the cycle count_out==0; busy falls same edge; more enables hold 0, no pulse.
//  T2 periodic: load 2, auto_reload=1, enable=1 x6 -> count_out 2,1,2,1,2,1,2;
//     done_pulse high 3 times, every 2nd cycle; busy stays 1.
//  T3 gating: load 5, enable pattern 1,0,0,1,1,0,1,1 -> decrements only on the 1s;
//     done_pulse after 5th enabled edge; count_out constant during enable=0.
//  T4 collisions: count_out=1, enable=1, load=1 value 7 -> count_out=7, no done_pulse;
//     clear and load same edge -> count_out=0, IDLE.
//  T5 async reset mid-run: load 9, 3 enabled edges (count 6), assert reset between
//     edges -> count_out=0, busy=0, zero=1 before next posedge; no done_pulse after release.
//  T6 bounds: load 0 -> IDLE, zero=1, never done; load 4'hF -> done after 15 enabled edges.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter / interval timer with one-cycle expiry pulse
// and optional periodic auto-reload.
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done_pulse,
  output logic             zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count_out  <= '0;
      reload_reg <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      count_out  <= count_n;
      reload_reg <= reload_n;
      done_pulse <= done_n;
    end
  end

  // Priority: clear > load > decrement; done only on an unpreempted terminal edge.
  always_comb begin
    state_n  = state;
    count_n  = count_out;
    reload_n = reload_reg;
    done_n   = 1'b0;
    if (clear) begin
      count_n = '0;
      state_n = IDLE;
    end else if (load) begin
      count_n  = load_value;
      reload_n = load_value;
      state_n  = (load_value != '0) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (count_out > WIDTH'(1)) begin
        count_n = count_out - WIDTH'(1);
      end else begin
        done_n = 1'b1;
        if (auto_reload) begin
          count_n = reload_reg;
        end else begin
          count_n = '0;
          state_n = IDLE;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign zero = (count_out == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; each observation packs
// {count_out, busy, done_pulse, zero} against a hand-computed value.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [3:0] count_out;
  logic       busy;
  logic       done_pulse;
  logic       zero;

  int vectors    = 0;
  int miscompares = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count_out   (count_out),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .zero        (zero)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; load = 1'b0; load_value = 4'd0;
    enable = 1'b0; auto_reload = 1'b0;
    #1;
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: got cnt=%0d busy=%b done=%b zero=%b, want cnt=0 busy=0 done=0 zero=1",
               count_out, busy, done_pulse, zero);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_one_shot();
    logic [6:0] exp [5] = '{{4'd3,3'b100}, {4'd2,3'b100}, {4'd1,3'b100},
                            {4'd0,3'b011}, {4'd0,3'b001}};
    load = 1'b1; load_value = 4'd3; enable = 1'b0; auto_reload = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0; enable = 1'b1;
      vectors++;
      if ({count_out, busy, done_pulse, zero} !== exp[i]) begin
        miscompares++;
        $display("FAIL one_shot[%0d]: got %b want %b", i, {count_out, busy, done_pulse, zero}, exp[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_periodic();
    logic [6:0] exp [9] = '{{4'd2,3'b100}, {4'd1,3'b100}, {4'd2,3'b110},
                            {4'd1,3'b100}, {4'd2,3'b110}, {4'd1,3'b100},
                            {4'd2,3'b110}, {4'd1,3'b100}, {4'd0,3'b011}};
    int pulses = 0;
    load = 1'b1; load_value = 4'd2; auto_reload = 1'b1; enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      load = 1'b0; enable = 1'b1;
      if (i == 6) auto_reload = 1'b0;
      if (done_pulse) pulses++;
      vectors++;
      if ({count_out, busy, done_pulse, zero} !== exp[i]) begin
        miscompares++;
        $display("FAIL periodic[%0d]: got %b want %b", i, {count_out, busy, done_pulse, zero}, exp[i]);
      end
    end
    vectors++;
    if (pulses !== 4) begin
      miscompares++;
      $display("FAIL periodic_pulses: got %0d want 4", pulses);
    end
    enable = 1'b0;
  endtask

  task automatic test_gating();
    logic       pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0] exp [8] = '{{4'd4,3'b100}, {4'd4,3'b100}, {4'd4,3'b100},
                            {4'd3,3'b100}, {4'd2,3'b100}, {4'd2,3'b100},
                            {4'd1,3'b100}, {4'd0,3'b011}};
    load = 1'b1; load_value = 4'd5; enable = 1'b0; auto_reload = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enable = pat[i];
      step();
      vectors++;
      if ({count_out, busy, done_pulse, zero} !== exp[i]) begin
        miscompares++;
        $display("FAIL gating[%0d]: got %b want %b", i, {count_out, busy, done_pulse, zero}, exp[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_collisions();
    load = 1'b1; load_value = 4'd2; enable = 1'b0;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    load = 1'b1; load_value = 4'd7;
    step();
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd7, 3'b100}) begin
      miscompares++;
      $display("FAIL load_on_terminal: got %b want %b", {count_out, busy, done_pulse, zero}, {4'd7, 3'b100});
    end
    clear = 1'b1; load_value = 4'd5;
    step();
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd0, 3'b001}) begin
      miscompares++;
      $display("FAIL clear_and_load: got %b want %b", {count_out, busy, done_pulse, zero}, {4'd0, 3'b001});
    end
    clear = 1'b0; load = 1'b1; load_value = 4'd1;
    step();
    load = 1'b0; clear = 1'b1;
    step();
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd0, 3'b001}) begin
      miscompares++;
      $display("FAIL clear_at_terminal: got %b want %b", {count_out, busy, done_pulse, zero}, {4'd0, 3'b001});
    end
    clear = 1'b0; enable = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_value = 4'd9; enable = 1'b0;
    step();
    load = 1'b0; enable = 1'b1;
    repeat (3) step();
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd6, 3'b100}) begin
      miscompares++;
      $display("FAIL pre_reset: got %b want %b", {count_out, busy, done_pulse, zero}, {4'd6, 3'b100});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd0, 3'b001}) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", {count_out, busy, done_pulse, zero}, {4'd0, 3'b001});
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({count_out, busy, done_pulse, zero} !== {4'd0, 3'b001}) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: got %b want %b", i, {count_out, busy, done_pulse, zero}, {4'd0, 3'b001});
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_bounds();
    logic [6:0] want;
    load = 1'b1; load_value = 4'd0; enable = 1'b0;
    step();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({count_out, busy, done_pulse, zero} !== {4'd0, 3'b001}) begin
        miscompares++;
        $display("FAIL load_zero[%0d]: got %b want %b", i, {count_out, busy, done_pulse, zero}, {4'd0, 3'b001});
      end
    end
    enable = 1'b0; load = 1'b1; load_value = 4'hF;
    step();
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd15, 3'b100}) begin
      miscompares++;
      $display("FAIL load_max: got %b want %b", {count_out, busy, done_pulse, zero}, {4'd15, 3'b100});
    end
    load = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      want = (i == 15) ? {4'd0, 3'b011} : {4'(15 - i), 3'b100};
      vectors++;
      if ({count_out, busy, done_pulse, zero} !== want) begin
        miscompares++;
        $display("FAIL max_run[%0d]: got %b want %b", i, {count_out, busy, done_pulse, zero}, want);
      end
    end
    step();
    vectors++;
    if ({count_out, busy, done_pulse, zero} !== {4'd0, 3'b001}) begin
      miscompares++;
      $display("FAIL max_after: got %b want %b", {count_out, busy, done_pulse, zero}, {4'd0, 3'b001});
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_gating();
    test_collisions();
    test_async_reset();
    test_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
